// File: rtl/echo_detector.sv
// Echo detector: post-burst blanking, N-sample confirmation, hysteresis release and timeout.
// Define ECHO_PEAK_TRACK_EN to build the peak-amplitude tracker; otherwise peak_out is tied to 0.
module echo_detector #(
  parameter int DATA_WIDTH    = 16,
  parameter int TIME_WIDTH    = 24,
  parameter int THRESHOLD_HI  = 300,
  parameter int THRESHOLD_LO  = 200,
  parameter int CONFIRM_COUNT = 3,
  parameter int BLANK_CYCLES  = 50000,
  parameter int TIMEOUT_TIME  = 16000000
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  arm_in,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid_in,
  input  logic [TIME_WIDTH-1:0] time_in,
  output logic                  echo_detected_out,
  output logic [TIME_WIDTH-1:0] echo_time_out,
  output logic [15:0]           echo_len_out,
  output logic [DATA_WIDTH-1:0] peak_out,
  output logic                  valid_out,
  output logic                  busy_out
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_BLANK   = 3'd1;
  localparam logic [2:0] ST_SEARCH  = 3'd2;
  localparam logic [2:0] ST_CONFIRM = 3'd3;
  localparam logic [2:0] ST_TRACK   = 3'd4;
  localparam logic [2:0] ST_DONE    = 3'd5;

  localparam logic [DATA_WIDTH-1:0] THR_HI    = DATA_WIDTH'(THRESHOLD_HI);
  localparam logic [DATA_WIDTH-1:0] THR_LO    = DATA_WIDTH'(THRESHOLD_LO);
  localparam logic [TIME_WIDTH-1:0] TIMEOUT_T = TIME_WIDTH'(TIMEOUT_TIME);
  localparam logic [31:0]           BLANK_N   = 32'(BLANK_CYCLES);
  localparam logic [15:0]           CONFIRM_N = 16'(CONFIRM_COUNT);

  logic [2:0]            state_q, state_d;
  logic [31:0]           blank_q, blank_d;
  logic [15:0]           run_q, run_d;
  logic [TIME_WIDTH-1:0] cand_time_q, cand_time_d;
  logic                  det_q, det_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [15:0]           len_q, len_d;
  logic                  valid_q, valid_d;
  logic                  busy_q, busy_d;

  logic        is_hi, is_below_lo, timeout;
  logic [15:0] run_next;

  assign is_hi       = (sample_in >= THR_HI);
  assign is_below_lo = (sample_in < THR_LO);
  assign timeout     = (time_in >= TIMEOUT_T);
  assign run_next    = run_q + 16'd1;

`ifdef ECHO_PEAK_TRACK_EN
  logic [DATA_WIDTH-1:0] peak_q, peak_d;
  logic [DATA_WIDTH-1:0] cand_peak_q, cand_peak_d;
  logic [DATA_WIDTH-1:0] cand_max, track_max;

  assign cand_max  = (sample_in > cand_peak_q) ? sample_in : cand_peak_q;
  assign track_max = (sample_in > peak_q) ? sample_in : peak_q;
  assign peak_out  = peak_q;
`else
  assign peak_out  = '0;
`endif

  always_comb begin
    state_d     = state_q;
    blank_d     = blank_q;
    run_d       = run_q;
    cand_time_d = cand_time_q;
    det_d       = det_q;
    time_d      = time_q;
    len_d       = len_q;
    valid_d     = 1'b0;
`ifdef ECHO_PEAK_TRACK_EN
    peak_d      = peak_q;
    cand_peak_d = cand_peak_q;
`endif
    // arm_in wins over everything, including a same-cycle sample or timeout
    if (arm_in) begin
      state_d     = ST_BLANK;
      blank_d     = BLANK_N;
      run_d       = '0;
      cand_time_d = '0;
      det_d       = 1'b0;
      time_d      = '0;
      len_d       = '0;
`ifdef ECHO_PEAK_TRACK_EN
      peak_d      = '0;
      cand_peak_d = '0;
`endif
    end else begin
      case (state_q)
        ST_BLANK: begin
          if (blank_q <= 32'd1) begin
            state_d = ST_SEARCH;
            blank_d = '0;
          end else begin
            blank_d = blank_q - 32'd1;
          end
        end
        ST_SEARCH: begin
          if (timeout) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else if (sample_valid_in && is_hi) begin
            cand_time_d = time_in;
            run_d       = 16'd1;
`ifdef ECHO_PEAK_TRACK_EN
            cand_peak_d = sample_in;
`endif
            if (CONFIRM_N == 16'd1) begin
              state_d = ST_TRACK;
              det_d   = 1'b1;
              time_d  = time_in;
              len_d   = CONFIRM_N;
`ifdef ECHO_PEAK_TRACK_EN
              peak_d  = sample_in;
`endif
            end else begin
              state_d = ST_CONFIRM;
            end
          end
        end
        ST_CONFIRM: begin
          if (timeout) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else if (sample_valid_in) begin
            if (is_hi) begin
              run_d = run_next;
`ifdef ECHO_PEAK_TRACK_EN
              cand_peak_d = cand_max;
`endif
              if (run_next == CONFIRM_N) begin
                state_d = ST_TRACK;
                det_d   = 1'b1;
                time_d  = cand_time_q;
                len_d   = CONFIRM_N;
`ifdef ECHO_PEAK_TRACK_EN
                peak_d  = cand_max;
`endif
              end
            end else begin
              state_d = ST_SEARCH;
              run_d   = '0;
            end
          end
        end
        ST_TRACK: begin
          // samples between LO and HI keep the echo alive (hysteresis)
          if (timeout) begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end else if (sample_valid_in) begin
            if (is_below_lo) begin
              state_d = ST_DONE;
              valid_d = 1'b1;
            end else begin
              len_d = (len_q == 16'hFFFF) ? len_q : len_q + 16'd1;
`ifdef ECHO_PEAK_TRACK_EN
              peak_d = track_max;
`endif
            end
          end
        end
        default: begin
        end
      endcase
    end
    busy_d = (state_d == ST_BLANK) || (state_d == ST_SEARCH) ||
             (state_d == ST_CONFIRM) || (state_d == ST_TRACK);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_IDLE;
      blank_q     <= '0;
      run_q       <= '0;
      cand_time_q <= '0;
      det_q       <= 1'b0;
      time_q      <= '0;
      len_q       <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
`ifdef ECHO_PEAK_TRACK_EN
      peak_q      <= '0;
      cand_peak_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      blank_q     <= blank_d;
      run_q       <= run_d;
      cand_time_q <= cand_time_d;
      det_q       <= det_d;
      time_q      <= time_d;
      len_q       <= len_d;
      valid_q     <= valid_d;
      busy_q      <= busy_d;
`ifdef ECHO_PEAK_TRACK_EN
      peak_q      <= peak_d;
      cand_peak_q <= cand_peak_d;
`endif
    end
  end

  assign echo_detected_out = det_q;
  assign echo_time_out     = time_q;
  assign echo_len_out      = len_q;
  assign valid_out         = valid_q;
  assign busy_out          = busy_q;

endmodule

// File: tb/tb_echo_detector.sv
// Self-checking bench for echo_detector: directed scenarios plus randomized pings
// compared cycle by cycle against a per-ping behavioural model.
module tb_echo_detector;

  localparam int HI    = 300;
  localparam int LO    = 200;
  localparam int CONF  = 3;
  localparam int BLANK = 40;
  localparam int TO    = 16000000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arm;
  logic        sv;
  logic [15:0] smp;
  logic [23:0] tin;
  logic        det;
  logic [23:0] etime;
  logic [15:0] elen;
  logic [15:0] peak;
  logic        vld;
  logic        busy;

  echo_detector #(
    .DATA_WIDTH(16), .TIME_WIDTH(24), .THRESHOLD_HI(HI), .THRESHOLD_LO(LO),
    .CONFIRM_COUNT(CONF), .BLANK_CYCLES(BLANK), .TIMEOUT_TIME(TO)
  ) dut (
    .clk_in(clk), .rst_in(rst_n), .arm_in(arm), .sample_in(smp),
    .sample_valid_in(sv), .time_in(tin), .echo_detected_out(det),
    .echo_time_out(etime), .echo_len_out(elen), .peak_out(peak),
    .valid_out(vld), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int    checks = 0;
  int    passed = 0;
  string phase  = "init";

  // Ping-level reference: armed/closed flags, remaining blank cycles, current high run
  bit mArmed, mClosed, mTracking;
  int mBlankLeft, mRunLen, mRunStart, mRunPeak;
  bit eDet, eValid;
  int eTime, eLen, ePeak;

  task automatic checkOutput(input string tag, input longint got, input longint exp);
    checks++;
    if (got == exp) passed++;
    else $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic modelReset();
    mArmed = 0; mClosed = 0; mTracking = 0;
    mBlankLeft = 0; mRunLen = 0; mRunStart = 0; mRunPeak = 0;
    eDet = 0; eValid = 0; eTime = 0; eLen = 0; ePeak = 0;
  endtask

  task automatic modelStep(input bit a, input bit v, input int s, input int t);
    eValid = 0;
    if (a) begin
      mArmed = 1; mClosed = 0; mTracking = 0; mRunLen = 0;
      mBlankLeft = (BLANK > 0) ? BLANK : 1;
      eDet = 0; eTime = 0; eLen = 0; ePeak = 0;
    end else if (!mArmed || mClosed) begin
    end else if (mBlankLeft > 0) begin
      mBlankLeft--;
    end else if (t >= TO) begin
      mClosed = 1; eValid = 1;
    end else if (v && mTracking) begin
      if (s < LO) begin
        mClosed = 1; eValid = 1;
      end else begin
        eLen = (eLen < 65535) ? eLen + 1 : 65535;
        if (s > ePeak) ePeak = s;
      end
    end else if (v) begin
      if (s >= HI) begin
        mRunLen++;
        if (mRunLen == 1) begin
          mRunStart = t; mRunPeak = s;
        end else if (s > mRunPeak) mRunPeak = s;
        if (mRunLen == CONF) begin
          mTracking = 1; eDet = 1; eTime = mRunStart; eLen = CONF; ePeak = mRunPeak;
        end
      end else begin
        mRunLen = 0;
      end
    end
  endtask

  task automatic compareAll();
    int expPeak;
`ifdef ECHO_PEAK_TRACK_EN
    expPeak = ePeak;
`else
    expPeak = 0;
`endif
    checkOutput({phase, ".detected"}, det, eDet);
    checkOutput({phase, ".echo_time"}, etime, eTime);
    checkOutput({phase, ".echo_len"}, elen, eLen);
    checkOutput({phase, ".peak"}, peak, expPeak);
    checkOutput({phase, ".valid"}, vld, eValid);
    checkOutput({phase, ".busy"}, busy, mArmed && !mClosed);
  endtask

  task automatic applyStimulus(input bit a, input bit v, input int s, input int t);
    arm = a; sv = v; smp = s[15:0]; tin = t[23:0];
    @(posedge clk);
    #1;
    modelStep(a, v, s, t);
    compareAll();
    arm = 1'b0; sv = 1'b0;
  endtask

  task automatic idleCycles(input int n, input int t);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, t);
  endtask

  task automatic armAndBlank();
    applyStimulus(1, 0, 0, 1000);
    idleCycles(BLANK + 1, 1000);
  endtask

  initial begin
    int t, n, r, s;
    bit a, v;
    rst_n = 1'b0; arm = 1'b0; sv = 1'b0; smp = '0; tin = '0;
    modelReset();

    phase = "reset";
    #2;
    compareAll();
    repeat (2) @(posedge clk);
    #1;
    compareAll();
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 1, 400, 100);

    phase = "blank";
    applyStimulus(1, 0, 0, 10);
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 400, 100 + i * 10);
    idleCycles(BLANK - 9, 1000);

    phase = "nominal";
    applyStimulus(0, 1, 350, 60000);
    applyStimulus(0, 0, 0, 60050);
    applyStimulus(0, 1, 350, 60100);
    applyStimulus(0, 1, 350, 60200);
    applyStimulus(0, 1, 500, 60300);
    applyStimulus(0, 1, 250, 60400);
    applyStimulus(0, 1, 150, 60500);
    idleCycles(2, 60600);

    phase = "glitch";
    armAndBlank();
    applyStimulus(0, 1, 350, 70000);
    applyStimulus(0, 1, 350, 70100);
    applyStimulus(0, 1, 100, 70200);
    applyStimulus(0, 1, 320, 80000);
    applyStimulus(0, 1, 320, 80100);
    applyStimulus(0, 1, 320, 80200);

    phase = "hysteresis";
    for (int i = 0; i < 10; i++) applyStimulus(0, 1, 250, 80300 + i * 100);
    applyStimulus(0, 1, 199, 82000);
    idleCycles(2, 82100);

    phase = "timeout";
    armAndBlank();
    for (int i = 0; i < 5; i++) applyStimulus(0, 1, 100, 100000 + i * 1000);
    applyStimulus(0, 1, 100, TO);
    idleCycles(2, TO + 1);

    phase = "priority";
    armAndBlank();
    applyStimulus(0, 1, 400, 90000);
    applyStimulus(0, 1, 400, 90100);
    applyStimulus(0, 1, 400, 90200);
    applyStimulus(0, 1, 400, 90300);
    applyStimulus(1, 1, 400, 90400);
    idleCycles(2, 90500);

    phase = "async_reset";
    armAndBlank();
    applyStimulus(0, 1, 350, 95000);
    applyStimulus(0, 1, 350, 95100);
    #2 rst_n = 1'b0;
    #1;
    modelReset();
    compareAll();
    #3 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 350, 95200 + i * 100);

    phase = "random";
    for (int p = 0; p < 40; p++) begin
      t = 1000;
      applyStimulus(1, 0, 0, t);
      n = $urandom_range(BLANK + 20, BLANK + 120);
      for (int c = 0; c < n; c++) begin
        a = ($urandom % 100) == 0;
        v = ($urandom % 4) != 0;
        r = $urandom % 5;
        case (r)
          0: s = $urandom_range(0, LO - 1);
          1: s = $urandom_range(LO, HI - 1);
          4: begin
            case ($urandom % 4)
              0: s = LO - 1;
              1: s = LO;
              2: s = HI - 1;
              default: s = HI;
            endcase
          end
          default: s = $urandom_range(HI, 1000);
        endcase
        t = t + $urandom_range(1, 100);
        if (($urandom % 60) == 0) t = TO + $urandom_range(0, 5);
        applyStimulus(a, v, s, t);
        if (a) t = 1000;
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
